// File: rtl/rr_reg_write_arbiter_if.sv
// Write-port bundle between N_REQ requesters and the shared register.
// master: requester side (drives req/req_data); slave: the arbiter (drives grant and register view).
interface rr_reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic [IDW-1:0]         q_src;
    logic                   q_loaded;
    logic                   busy;

    modport master (
        output req, req_data,
        input  gnt, q, q_src, q_loaded, busy
    );

    modport slave (
        input  req, req_data,
        output gnt, q, q_src, q_loaded, busy
    );
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter owning one WIDTH-bit register, with optional GAP idle cycles after each write.
// Ports: clk, sync_rst (sync, active-high), bus (slave: req/req_data in; gnt/q/q_src/q_loaded/busy out).
module rr_reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input logic                  clk,
    input logic                  sync_rst,
    rr_reg_write_arbiter_if.slave bus
);
    localparam int IDW = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ);
    localparam int CW  = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic {
        S_ARB,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IDW-1:0]   src_q, src_d;
    logic             loaded_q, loaded_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] eligible;
    logic [IDW:0]     idx;
    logic [IDW-1:0]   win;
    logic             found;

    always_comb begin
        // a requester is masked in its grant cycle so a held req is not granted twice
        eligible = bus.req & ~gnt_q;
        idx      = '0;
        win      = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!found && eligible[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        q_d      = q_q;
        src_d    = src_q;
        loaded_d = loaded_q;
        unique case (state_q)
            S_ARB: begin
                if (found) begin
                    q_d      = bus.req_data[win*WIDTH +: WIDTH];
                    src_d    = win;
                    gnt_d    = N_REQ'(1) << win;
                    loaded_d = 1'b1;
                    ptr_d    = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = CW'(GAP);
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
        // busy spans the grant cycle and every idle cycle before the next possible grant
        busy_d = (state_d == S_GAP) || (state_q == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q  <= S_ARB;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            q_q      <= '0;
            src_q    <= '0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            q_q      <= q_d;
            src_q    <= src_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.q        = q_q;
    assign bus.q_src    = src_q;
    assign bus.q_loaded = loaded_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/rr_reg_write_arbiter.md
Name: rr_reg_write_arbiter

Overview:
- Shares the write port of a single WIDTH-bit data register among N_REQ requesters.
- Uses round-robin arbitration and a per-requester request/grant handshake.
- Optionally enforces a fixed number of idle cycles after each write.
- Sits in front of the register bank so that multiple producers can update one shared configuration/data word without collisions.

Parameters:
- N_REQ, 4: number of requesters; must be >= 2; non-power-of-two values are supported.
- WIDTH, 4: data width of the register.
- GAP, 0: number of idle cycles enforced after each write; 0 allows a write every cycle.
- IDW (localparam), max(1, $clog2(N_REQ)): width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- sync_rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  req[i]=1: requester i requests a write.
- req_data  input  N_REQ*WIDTH  slice [i*WIDTH +: WIDTH] is requester i's write data.
- gnt  output  N_REQ  one-hot registered grant pulse; gnt[i]=1 for exactly one cycle when requester i's data is written.
- q  output  WIDTH  current register contents.
- q_src  output  IDW  index of the requester that last wrote q.
- q_loaded  output  1  1 once any write has occurred since reset.
- busy  output  1  1 while the block is in the GAP state.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is sync_rst, synchronous and active-high.
  - sync_rst has priority over every other event at a clock edge.
- Reset values (cycle after the edge where sync_rst=1): q=0, q_src=0, q_loaded=0, gnt=0, busy=0, state=ARB, round-robin pointer ptr=0, gap counter=0.
- Handshake:
  - Requester i holds req[i]=1 and req_data slice i stable until it sees gnt[i]=1.
  - It may deassert, or present new data with req[i] held, from the cycle after gnt[i].
  - During any cycle with gnt[i]=1, req[i] is masked (ignored), so a held req is never double-granted.
- Eligible set: req & ~gnt.
- ARB state:
  - If the eligible set is empty: no change; gnt=0 next cycle.
  - Otherwise the winner w is the first eligible index scanning ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
  - At that edge: q <= req_data[w]; q_src <= w; gnt <= one-hot(w); q_loaded <= 1; ptr <= (w+1) mod N_REQ.
  - If GAP>0: state <= GAP and counter <= GAP. Otherwise stay in ARB.
- Latency: a request sampled at edge t produces gnt and the updated q visible after edge t, one cycle later.
- GAP state:
  - busy=1; gnt is 0 after its first cycle; no arbitration.
  - Counter decrements each cycle; when counter==1, state <= ARB.
  - This gives exactly GAP idle cycles between the grant cycle and the next possible grant.
  - Requests arriving during GAP are held by the requesters and arbitrated in the first ARB cycle.
- Simultaneous requests: exactly one grant per arbitration cycle. Losers keep requesting. Fairness: with all requesters continuously active, each is granted once every N_REQ grants.
- Wrap-around: ptr and the scan wrap modulo N_REQ, including non-power-of-two N_REQ. ptr never takes a value >= N_REQ.
- Reset mid-operation: sync_rst during ARB or GAP aborts any gap, clears q, ptr, q_src, q_loaded and gnt, and returns to ARB. Pending requests are re-arbitrated from ptr=0 after reset deasserts.
- Outputs: all outputs are registered; no combinational path from req to any output.

Test Plan:
1. Idle: sync_rst 2 cycles, then req=0000 for 10 cycles -> gnt=0000, q=0, q_src=0, q_loaded=0, busy=0 throughout.
2. Single write (N_REQ=4, WIDTH=4, GAP=0): req[2]=1 with data 4'hA at edge t -> after t: gnt=0100 for one cycle, q=4'hA, q_src=2, q_loaded=1. Requester drops req -> gnt=0000 and q holds 4'hA.
3. Round-robin (GAP=0): all req held at 1, data i = 4'h1+i -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. q follows 1, 2, 3, 4, 1.
4. Gap spacing (GAP=2): req[1] and req[3] both held -> gnt[1] in cycle c, busy=1 in c..c+2, gnt=0 in c+1..c+2, gnt[3] in c+3.
5. Reset mid-gap (GAP=3, ptr=2, q=4'h7): sync_rst=1 for 1 cycle during GAP -> next cycle q=0, q_loaded=0, busy=0. With req[1] and req[3] held, the following grant goes to 1 because ptr=0.
6. Non-power-of-two wrap (N_REQ=3): grant to 1 (ptr becomes 2), then req[0] and req[2] held -> grant 2, then grant 0; ptr returns to 1. ptr is never 3.
